// File: rtl/vga_fb_arbiter.sv
// Frame-buffer arbiter: upscaled XGA scan-out reads get fixed slots, a valid/ready writer gets the rest.
// Optional macro FB_VBLANK_ONLY_EN: writer is granted only outside ACTIVE (tear-free writing).
module vga_fb_arbiter #(
    parameter int IMG_W      = 256,
    parameter int IMG_H      = 192,
    parameter int SCALE_LOG2 = 2,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 12,
    parameter int V_ACT      = 768
) (
    input  logic              clk_vga,
    input  logic              rst,
    input  logic [10:0]       pix_x,
    input  logic [10:0]       pix_y,
    input  logic              pix_de,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] rgb_out,
    output logic              de_out,
    output logic              frame_done
);

    typedef enum logic [1:0] {ST_SYNC, ST_ACTIVE, ST_VBLANK} state_t;

    localparam int LINE_W = $clog2(V_ACT + 1);

    if (IMG_W * IMG_H > (1 << ADDR_W)) begin : g_bad_cfg
        $error("vga_fb_arbiter: IMG_W*IMG_H does not fit in ADDR_W address bits");
    end

    state_t            state;
    logic [LINE_W-1:0] line_cnt;
    logic              de_d1;
    logic              de_d2;
    logic              rd_d1;
    logic              rd_d2;
    logic              disp_slot;
    logic              de_rise;
    logic              de_fall;
    logic [ADDR_W-1:0] rd_addr;

    assign de_rise   = pix_de && !de_d1;
    assign de_fall   = !pix_de && de_d1;
    assign disp_slot = (state == ST_ACTIVE) && pix_de && (pix_x[SCALE_LOG2-1:0] == '0);

    // Downscaled row/column into the stored image; IMG_W is constant, so a power of 2 becomes a shift.
    assign rd_addr = ADDR_W'(ADDR_W'(pix_y >> SCALE_LOG2) * ADDR_W'(IMG_W))
                   + ADDR_W'(pix_x >> SCALE_LOG2);

`ifdef FB_VBLANK_ONLY_EN
    assign wr_ready = !rst && (state != ST_ACTIVE);
`else
    assign wr_ready = !rst && !disp_slot;
`endif

    always_ff @(posedge clk_vga) begin
        if (rst) begin
            state      <= ST_SYNC;
            line_cnt   <= '0;
            de_d1      <= 1'b0;
            de_d2      <= 1'b0;
            de_out     <= 1'b0;
            rd_d1      <= 1'b0;
            rd_d2      <= 1'b0;
            rgb_out    <= '0;
            frame_done <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            de_d1      <= pix_de;
            de_d2      <= de_d1;
            de_out     <= de_d2;
            rd_d1      <= disp_slot;
            rd_d2      <= rd_d1;
            frame_done <= 1'b0;

            // Read data lands two cycles after the slot; blank whenever the delayed enable is low.
            if (!de_d2) begin
                rgb_out <= '0;
            end else if (rd_d2) begin
                rgb_out <= mem_rdata;
            end

            if (disp_slot) begin
                mem_en   <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= rd_addr;
            end else if (wr_valid && wr_ready) begin
                mem_en    <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= wr_addr;
                mem_wdata <= wr_data;
            end else begin
                mem_en <= 1'b0;
                mem_we <= 1'b0;
            end

            case (state)
                ST_SYNC: begin
                    if (pix_de && pix_x == '0 && pix_y == '0) begin
                        state <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (de_fall) begin
                        if (line_cnt == LINE_W'(V_ACT - 1)) begin
                            state      <= ST_VBLANK;
                            frame_done <= 1'b1;
                            line_cnt   <= '0;
                        end else begin
                            line_cnt <= line_cnt + 1'b1;
                        end
                    end
                end
                ST_VBLANK: begin
                    // A rise on any row but 0 means we lost lock with the timing generator.
                    if (de_rise) begin
                        state <= (pix_y == '0) ? ST_ACTIVE : ST_SYNC;
                    end
                end
                default: state <= ST_SYNC;
            endcase
        end
    end

endmodule
